// File: rtl/seg_pkg.sv
// Shared constants for the display path: digit count, character codes and
// active-low segment patterns (bit7=a .. bit1=g, bit0=dp).
package seg_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [4:0] CH_H     = 5'h10;
    localparam logic [4:0] CH_L     = 5'h11;
    localparam logic [4:0] CH_P     = 5'h12;
    localparam logic [4:0] CH_U     = 5'h13;
    localparam logic [4:0] CH_MINUS = 5'h14;
    localparam logic [4:0] CH_BLANK = 5'h1F;

    localparam logic [7:0] SEG_H     = 8'b10010001;
    localparam logic [7:0] SEG_L     = 8'b11100011;
    localparam logic [7:0] SEG_P     = 8'b00110001;
    localparam logic [7:0] SEG_U     = 8'b10000011;
    localparam logic [7:0] SEG_MINUS = 8'b11111101;
    localparam logic [7:0] SEG_OFF   = 8'hFF;

    function automatic logic [7:0] hex_seg(input logic [3:0] nib);
        logic [7:0] p;
        case (nib)
            4'h0: p = 8'b00000011;
            4'h1: p = 8'b10011111;
            4'h2: p = 8'b00100101;
            4'h3: p = 8'b00001101;
            4'h4: p = 8'b10011001;
            4'h5: p = 8'b01001001;
            4'h6: p = 8'b01000001;
            4'h7: p = 8'b00011111;
            4'h8: p = 8'b00000001;
            4'h9: p = 8'b00001001;
            4'hA: p = 8'b00010001;
            4'hB: p = 8'b11000001;
            4'hC: p = 8'b01100011;
            4'hD: p = 8'b10000101;
            4'hE: p = 8'b01100001;
            default: p = 8'b01110001;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Write port and display outputs of the digit scanner.
// Optional SEG_DP_EN adds the per-digit decimal-point mask.
interface seg_scan_if;
    logic       en;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic [7:0] seg;
    logic [5:0] sel;
`ifdef SEG_DP_EN
    logic [5:0] dp_mask;

    modport master (output en, wr_en, wr_addr, wr_data, dp_mask, input seg, sel);
    modport slave  (input en, wr_en, wr_addr, wr_data, dp_mask, output seg, sel);
`else
    modport master (output en, wr_en, wr_addr, wr_data, input seg, sel);
    modport slave  (input en, wr_en, wr_addr, wr_data, output seg, sel);
`endif
endinterface

// File: rtl/seg_decode.sv
// Combinational 5-bit character code to active-low segment pattern, dp off.
module seg_decode
    import seg_pkg::*;
(
    input  logic [4:0] code_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        if (code_i[4] == 1'b0) begin
            seg_o = hex_seg(code_i[3:0]);
        end else begin
            case (code_i)
                CH_H:     seg_o = SEG_H;
                CH_L:     seg_o = SEG_L;
                CH_P:     seg_o = SEG_P;
                CH_U:     seg_o = SEG_U;
                CH_MINUS: seg_o = SEG_MINUS;
                default:  seg_o = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan.sv
// Six-digit scan controller: buffer, dwell counter and registered seg/sel.
// Define SEG_DP_EN to drive seg[0] from the interface dp_mask.
module seg_scan
    import seg_pkg::*;
#(
    parameter int DWELL = 50000,
    parameter int CNT_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   bus
);

    logic [4:0]       buf_q [NUM_DIGITS];
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       sel_q, sel_d;
    logic [7:0]       seg_q, seg_d;
    logic [7:0]       dec_seg;

    seg_decode u_decode (
        .code_i (buf_q[idx_q]),
        .seg_o  (dec_seg)
    );

    // seg and sel come from the same idx in the same cycle, so they always move together.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        sel_d = 6'b0;
        seg_d = SEG_OFF;
        if (bus.en) begin
            if (cnt_q == CNT_W'(DWELL - 1)) begin
                cnt_d = '0;
                idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            sel_d = 6'b000001 << idx_q;
            seg_d = dec_seg;
`ifdef SEG_DP_EN
            seg_d[0] = ~bus.dp_mask[idx_q];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= CH_BLANK;
            idx_q <= '0;
            cnt_q <= '0;
            sel_q <= '0;
            seg_q <= SEG_OFF;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            seg_q <= seg_d;
            if (bus.wr_en && (bus.wr_addr < 3'(NUM_DIGITS))) begin
                buf_q[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    assign bus.seg = seg_q;
    assign bus.sel = sel_q;

endmodule
